// File: rtl/mmio_manager.sv
// MMIO manager: splits the data-memory space into RAM and per-channel
// sensor/actuator registers with new/overrun flags and 1-cycle reads.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   addr, wren, rden    processor word address, store and load strobes
//   dataIn              processor store data
//   RAMDataOut          synchronous-read RAM data (1-cycle latency)
//   ram_wEn             RAM write enable, gated to addresses below MMIO_BASE
//   ch_in_data/valid    per-channel sensor capture data and strobe
//   ch_out_data/wr      per-channel output register and 1-cycle write pulse
//   pending             OR of all channel new flags
//   dataOut             load data returned to the processor
module mmio_manager #(
   parameter int          NUM_CH    = 4,
   parameter int          DATA_W    = 32,
   parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [31:0]              addr,
   input  logic                     wren,
   input  logic                     rden,
   input  logic [DATA_W-1:0]        dataIn,
   input  logic [DATA_W-1:0]        RAMDataOut,
   output logic                     ram_wEn,
   input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
   input  logic [NUM_CH-1:0]        ch_in_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_out_data,
   output logic [NUM_CH-1:0]        ch_out_wr,
   output logic                     pending,
   output logic [DATA_W-1:0]        dataOut
);

   logic              is_mmio;
   logic [31:0]       off;
   logic [NUM_CH-1:0] hit_ch;
   logic              hit_st;
   logic              hit_ov;

   logic [DATA_W-1:0] in_reg [NUM_CH];
   logic [NUM_CH-1:0] new_flag;
   logic [NUM_CH-1:0] ovr;
   logic [DATA_W-1:0] mmio_q;
   logic              src_mmio;

   logic [NUM_CH-1:0] rd_hit;
   logic [NUM_CH-1:0] st_clr;
   logic [NUM_CH-1:0] ov_clr;
   logic [NUM_CH-1:0] new_nxt;
   logic [NUM_CH-1:0] ovr_nxt;
   logic [DATA_W-1:0] rd_val;

   assign is_mmio = (addr >= MMIO_BASE);
   assign off     = addr - MMIO_BASE;

   always_comb begin
      hit_ch = '0;
      for (int i = 0; i < NUM_CH; i++)
         hit_ch[i] = is_mmio && (off == 32'(i));
      hit_st = is_mmio && (off == 32'(NUM_CH));
      hit_ov = is_mmio && (off == 32'(NUM_CH + 1));
   end

   assign ram_wEn = wren && !is_mmio;
   assign pending = |new_flag;
   assign dataOut = src_mmio ? mmio_q : RAMDataOut;

   // A capture always wins over any clear on the same edge; a read that
   // coincides with a capture neither clears new nor counts as overrun.
   always_comb begin
      rd_hit  = rden ? hit_ch : '0;
      st_clr  = (wren && hit_st) ? dataIn[NUM_CH-1:0] : '0;
      ov_clr  = (wren && hit_ov) ? dataIn[NUM_CH-1:0] : '0;
      new_nxt = ch_in_valid | (new_flag & ~rd_hit & ~st_clr);
      ovr_nxt = (ch_in_valid & new_flag & ~rd_hit) | (ovr & ~ov_clr);
   end

   // Read mux uses the pre-edge register values, so a same-edge capture
   // returns the old channel data.
   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         hit_st:  rd_val[NUM_CH-1:0] = new_flag;
         hit_ov:  rd_val[NUM_CH-1:0] = ovr;
         default: begin
            for (int i = 0; i < NUM_CH; i++)
               if (hit_ch[i]) rd_val = in_reg[i];
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++)
            in_reg[i] <= '0;
         ch_out_data <= '0;
         ch_out_wr   <= '0;
         new_flag    <= '0;
         ovr         <= '0;
         mmio_q      <= '0;
         src_mmio    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_in_valid[i])
               in_reg[i] <= ch_in_data[i*DATA_W +: DATA_W];
            if (wren && hit_ch[i])
               ch_out_data[i*DATA_W +: DATA_W] <= dataIn;
         end
         ch_out_wr <= wren ? hit_ch : '0;
         new_flag  <= new_nxt;
         ovr       <= ovr_nxt;
         mmio_q    <= rd_val;
         src_mmio  <= is_mmio;
      end
   end

endmodule

// File: doc/mmio_manager.md
MMIO_MANAGER -- requirements
Module: mmio_manager

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of peripheral channels (1..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The block SHALL have parameter MMIO_BASE, default 32'h0000_1000, giving the first MMIO word address; addresses below it are RAM.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clock).
REQ-006 The block SHALL have port addr, input, 32 bits: processor data-memory word address.
REQ-007 The block SHALL have port wren, input, 1 bit: processor store strobe.
REQ-008 The block SHALL have port rden, input, 1 bit: processor load strobe, used only for read side effects.
REQ-009 The block SHALL have port dataIn, input, DATA_W bits: processor store data.
REQ-010 The block SHALL have port RAMDataOut, input, DATA_W bits: synchronous-read RAM output (1-cycle latency).
REQ-011 The block SHALL have port ram_wEn, output, 1 bit: gated RAM write enable.
REQ-012 The block SHALL have port ch_in_data, input, NUM_CH*DATA_W bits: per-channel sensor data, channel i at bits [i*DATA_W +: DATA_W].
REQ-013 The block SHALL have port ch_in_valid, input, NUM_CH bits: per-channel one-cycle capture strobe.
REQ-014 The block SHALL have port ch_out_data, output, NUM_CH*DATA_W bits: per-channel registered output data.
REQ-015 The block SHALL have port ch_out_wr, output, NUM_CH bits: per-channel one-cycle write pulse.
REQ-016 The block SHALL have port pending, output, 1 bit: OR of all channel new flags.
REQ-017 The block SHALL have port dataOut, output, DATA_W bits: read data returned to the processor.

Function
REQ-018 The block SHALL decode offset = addr - MMIO_BASE when addr >= MMIO_BASE: offsets 0..NUM_CH-1 = channel i, NUM_CH = STATUS, NUM_CH+1 = OVERRUN, anything higher = unmapped.
REQ-019 The block SHALL drive ram_wEn = wren AND (addr < MMIO_BASE), combinationally.
REQ-020 The block SHALL latch ch_in_data[i] into in_reg[i] on every edge where ch_in_valid[i]=1.
REQ-021 The block SHALL set new[i] when ch_in_valid[i]=1, and SHALL clear new[i] on an edge where rden=1 addresses channel i and ch_in_valid[i]=0.
REQ-022 The block SHALL set sticky ovr[i] when ch_in_valid[i]=1 while new[i]=1, unless the same edge is a qualifying read of channel i.
REQ-023 When ch_in_valid[i] coincides with a read of channel i, the block SHALL return the old in_reg[i], capture the new data, and leave new[i]=1 with ovr[i] unchanged.
REQ-024 A write with wren=1 to channel i SHALL load ch_out_data[i] from dataIn and pulse ch_out_wr[i] high for exactly the following cycle.
REQ-025 Writes to STATUS SHALL clear new[i] for each dataIn[i]=1, writes to OVERRUN SHALL clear ovr[i] for each dataIn[i]=1, and in both cases a same-edge set SHALL win over the clear.
REQ-026 Writes to unmapped offsets SHALL be ignored, and reads of unmapped offsets SHALL return 0.
REQ-027 Reads SHALL have 1-cycle latency: at each edge the block SHALL register src_mmio = (addr >= MMIO_BASE) and mmio_q = the decoded MMIO value (in_reg[i], zero-extended new vector, zero-extended ovr vector, or 0).
REQ-028 The block SHALL drive dataOut = src_mmio ? mmio_q : RAMDataOut.
REQ-029 The block SHALL drive pending = |new combinationally from the registered flags.
REQ-030 MMIO reads SHALL occur regardless of rden; only flag-clearing side effects SHALL require rden=1.

Reset
REQ-031 With reset=0 at an edge, the block SHALL clear in_reg, ch_out_data, ch_out_wr, new, ovr, mmio_q and src_mmio to 0, so that dataOut = RAMDataOut, pending = 0 and ram_wEn remains combinational.
REQ-032 Reset SHALL take priority over any simultaneous valid, read or write, including one arriving mid-transaction.

Verification
REQ-033 Verification SHALL cover: store 0xDEADBEEF to addr 0x10 -> ram_wEn=1 that cycle, no ch_out_wr; load 0x10 next cycle -> dataOut=RAMDataOut.
REQ-034 Verification SHALL cover: ch_in_valid[2]=1 with data 0x55; load addr 0x1002 with rden=1 -> dataOut=0x55 one cycle later, pending goes 1->0, STATUS reads 0.
REQ-035 Verification SHALL cover: two valids on channel 1 (0x11, then 0x22) with no read -> OVERRUN reads 0x2, channel reads 0x22; writing 0x2 to 0x1005 -> OVERRUN reads 0.
REQ-036 Verification SHALL cover: store 0xA5 to 0x1003 -> ch_out_data[3]=0xA5 and ch_out_wr=4'b1000 for exactly one cycle, ram_wEn=0.
REQ-037 Verification SHALL cover: a same-edge valid (0x77) and read of channel 0 holding 0x66 -> returns 0x66, new[0] stays 1, the next read returns 0x77.
REQ-038 Verification SHALL cover: reset=0 asserted while new=4'hF and ovr=4'h3 -> all flags 0, pending=0; a load of 0x1007 returns 0.
